pc_ctrl: RTL
============

# pc_ctrl

Parametrised program-counter controller for the NPC core, the successor to the single-cycle write-back PC register. It owns the architectural PC, issues fetch requests to the IFU over a valid/ready handshake, and accepts instruction commits from the write-back stage over a second valid/ready handshake. On each commit it selects the next PC from branch, jump, trap and mret sources, checks the target for misalignment, raises exceptions toward the CSR file, and counts retired instructions.

## Interface

Parameters:
- XLEN, 32: datapath and PC width.
- PC_START, 32'h8000_0000: PC loaded by reset, zero-extended or truncated to XLEN.
- IALIGN, 32: instruction alignment in bits. Legal values are 32 (target[1:0] must be 0) and 16 (target[0] must be 0).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- fetch_valid, out, 1: fetch request for fetch_pc.
- fetch_ready, in, 1: IFU accepts the request.
- fetch_pc, out, XLEN: address to fetch; equals pc.
- pc, out, XLEN: PC of the instruction currently in flight.
- commit_valid, in, 1: the instruction at pc has completed execution and LSU access.
- commit_ready, out, 1: the controller can accept a commit.
- br_taken, in, 1: taken conditional branch. br_target, in, XLEN: its target.
- is_jal, in, 1: JAL. jal_target, in, XLEN: its target.
- is_jalr, in, 1: JALR. jalr_target, in, XLEN: its target; bit 0 is cleared internally.
- is_mret, in, 1: MRET. mepc, in, XLEN: return address.
- trap_req, in, 1: synchronous trap (ecall, ebreak, illegal) from EXU.
- trap_cause, in, 4: cause code for trap_req.
- trap_tval, in, XLEN: tval for trap_req.
- mtvec, in, XLEN: trap vector (direct mode only).
- exc_valid, out, 1: one-cycle exception pulse to the CSR file.
- exc_cause, out, 4: exception cause. exc_pc, out, XLEN: faulting PC. exc_tval, out, XLEN: exception tval.
- instret, out, 64: retired-instruction count.

## Operation

- States:
  - BOOT: entered on reset; lasts one cycle, then moves to FETCH.
  - FETCH: fetch_valid=1. On fetch_valid && fetch_ready, moves to EXEC.
  - EXEC: commit_ready=1. On commit_valid && commit_ready, updates pc and moves to FETCH.
- Handshake rules:
  - commit_valid is ignored outside EXEC.
  - fetch_ready is ignored outside FETCH.
  - fetch_pc is stable while fetch_valid is high.
- Next-PC priority, evaluated on an accepted commit, first match wins:
  1. trap_req
  2. misaligned target
  3. is_mret
  4. br_taken
  5. is_jal
  6. is_jalr
  7. pc+4
- Multiple asserted control-flow sources are resolved by this priority and are not an error.
- Misaligned target: the selected br/jal/jalr target violates IALIGN.
  - Raise cause 0 (EXC_INST_MISALIGNED) with tval = the offending target.
  - Next pc = trap vector.
- trap_req: raise trap_cause with tval = trap_tval. Next pc = trap vector.
- Trap vector = {mtvec[XLEN-1:2], 2'b00}.
- mret target = mepc with alignment bits cleared. An mret target is never misaligned.
- On any exception, exc_pc = pc at the time of the commit.
- pc+4 wraps modulo 2^XLEN. Targets wrap the same way.
- instret increments by 1 per accepted commit that raises no exception. It wraps at 2^64.

## Timing

- Reset values:
  - state=BOOT, pc=PC_START, instret=0.
  - fetch_valid=0, commit_ready=0, exc_valid=0, exc_cause=0, exc_pc=0, exc_tval=0.
- fetch_valid and commit_ready are decoded from state only, with no combinational path from inputs.
- exc_valid, exc_cause, exc_pc and exc_tval are registered. The pulse appears in the cycle after the commit edge and lasts exactly one cycle, coinciding with the first FETCH cycle of the new pc.
- Latency:
  - Commit edge to fetch_valid of the next pc: 1 cycle.
  - Minimum steady state with fetch_ready and commit_valid tied high: 2 cycles per instruction.
- Reset asserted mid-FETCH or mid-EXEC: at the next edge, all state returns to its reset values. Any pending handshake is dropped and no exc_valid is produced.

## Structure

- Package pc_ctrl_pkg holds:
  - the state enum (BOOT, FETCH, EXEC);
  - EXC_INST_MISALIGNED = 4'd0;
  - the 4-bit cause width constant.
- Sub-module pc_redirect_mux: purely combinational.
  - Inputs: all redirect sources plus pc.
  - Outputs: next_pc, is_exc, exc_cause, exc_tval.
  - Implements the priority and IALIGN checks.
- pc_ctrl holds the FSM, pc, instret and the exception registers.

## Test plan

- Reset release, fetch_ready=1, commit_valid=1:
  - fetch_pc = 0x8000_0000, then 0x8000_0004, then 0x8000_0008.
  - instret = 3 after three commits.
- Commit with br_taken=1, br_target=0x8000_0100, is_jal=1, jal_target=0x8000_0200: next fetch_pc = 0x8000_0100.
- IALIGN=32, commit with is_jalr=1, jalr_target=0x8000_0006, mtvec=0x8000_1001:
  - exc_valid pulse with cause 0, tval 0x8000_0006, exc_pc = old pc.
  - next pc = 0x8000_1000; instret unchanged.
- Same jalr target with IALIGN=16: no exception, next pc = 0x8000_0006.
- trap_req=1 with cause 11 alongside is_mret=1: trap wins, next pc = trap vector. A following mret with mepc=0x8000_0010 gives next pc = 0x8000_0010.
- fetch_ready held low for 5 cycles: fetch_pc stable and commit_ready=0. rst asserted in cycle 3: pc = PC_START and state BOOT after the edge.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter controller.
package pc_ctrl_pkg;

    // Width of exception cause codes handed to the CSR file
    localparam int CAUSE_W = 4;

    // Cause code for an instruction-address-misaligned exception
    localparam logic [CAUSE_W-1:0] EXC_INST_MISALIGNED = 4'd0;

    // Controller sequencing states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_redirect_mux.sv
// Next-PC selection for a committing instruction: applies the redirect
// priority (trap, misaligned target, mret, branch, jal, jalr, sequential)
// and flags exceptions together with their cause and tval.
module pc_redirect_mux
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic [XLEN-1:0]    i_pc,
    input  logic               i_br_taken,
    input  logic [XLEN-1:0]    i_br_target,
    input  logic               i_is_jal,
    input  logic [XLEN-1:0]    i_jal_target,
    input  logic               i_is_jalr,
    input  logic [XLEN-1:0]    i_jalr_target,
    input  logic               i_is_mret,
    input  logic [XLEN-1:0]    i_mepc,
    input  logic               i_trap_req,
    input  logic [CAUSE_W-1:0] i_trap_cause,
    input  logic [XLEN-1:0]    i_trap_tval,
    input  logic [XLEN-1:0]    i_mtvec,
    output logic [XLEN-1:0]    o_next_pc,
    output logic               o_is_exc,
    output logic [CAUSE_W-1:0] o_exc_cause,
    output logic [XLEN-1:0]    o_exc_tval
);

    // Low address bits that must be zero for a legal instruction address
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

    logic [XLEN-1:0] w_trap_vec;
    logic [XLEN-1:0] w_mret_pc;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_tgt;
    logic            w_has_tgt;
    logic            w_misaligned;

    // Direct-mode vector ignores the mode bits; mret and sequential
    // targets are aligned by construction, so they never fault.
    assign w_trap_vec = i_mtvec & ~XLEN'(3);
    assign w_mret_pc  = i_mepc & ~ALIGN_MASK;
    assign w_seq_pc   = i_pc + XLEN'(4);

    // Pick the control-transfer target that would win among br/jal/jalr
    always_comb begin
        w_has_tgt = 1'b1;
        w_tgt     = '0;
        if (i_br_taken) begin
            w_tgt = i_br_target;
        end else if (i_is_jal) begin
            w_tgt = i_jal_target;
        end else if (i_is_jalr) begin
            w_tgt = i_jalr_target & ~XLEN'(1);
        end else begin
            w_has_tgt = 1'b0;
        end
    end

    assign w_misaligned = w_has_tgt && ((w_tgt & ALIGN_MASK) != '0);

    // Resolve the redirect priority; first match wins
    always_comb begin
        o_next_pc   = w_seq_pc;
        o_is_exc    = 1'b0;
        o_exc_cause = '0;
        o_exc_tval  = '0;
        if (i_trap_req) begin
            o_next_pc   = w_trap_vec;
            o_is_exc    = 1'b1;
            o_exc_cause = i_trap_cause;
            o_exc_tval  = i_trap_tval;
        end else if (w_misaligned) begin
            o_next_pc   = w_trap_vec;
            o_is_exc    = 1'b1;
            o_exc_cause = EXC_INST_MISALIGNED;
            o_exc_tval  = w_tgt;
        end else if (i_is_mret) begin
            o_next_pc = w_mret_pc;
        end else if (w_has_tgt) begin
            o_next_pc = w_tgt;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: owns the architectural PC, issues fetches,
// accepts commits, redirects on control flow and traps, raises exceptions
// toward the CSR file and counts retired instructions.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. o_fetch_valid is high for the whole FETCH state and
// o_fetch_pc does not change while it is high; o_commit_ready is high for
// the whole EXEC state. Both are registered and depend on state only, and
// each side ignores the partner's signal outside its own state.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] PC_START = 32'h8000_0000,
    parameter int          IALIGN   = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               o_fetch_valid,
    input  logic               i_fetch_ready,
    output logic [XLEN-1:0]    o_fetch_pc,
    output logic [XLEN-1:0]    o_pc,
    input  logic               i_commit_valid,
    output logic               o_commit_ready,
    input  logic               i_br_taken,
    input  logic [XLEN-1:0]    i_br_target,
    input  logic               i_is_jal,
    input  logic [XLEN-1:0]    i_jal_target,
    input  logic               i_is_jalr,
    input  logic [XLEN-1:0]    i_jalr_target,
    input  logic               i_is_mret,
    input  logic [XLEN-1:0]    i_mepc,
    input  logic               i_trap_req,
    input  logic [CAUSE_W-1:0] i_trap_cause,
    input  logic [XLEN-1:0]    i_trap_tval,
    input  logic [XLEN-1:0]    i_mtvec,
    output logic               o_exc_valid,
    output logic [CAUSE_W-1:0] o_exc_cause,
    output logic [XLEN-1:0]    o_exc_pc,
    output logic [XLEN-1:0]    o_exc_tval,
    output logic [63:0]        o_instret,
    output state_t             o_state
);

    localparam logic [XLEN-1:0] PC_RESET = XLEN'(PC_START);

    state_t             r_state;
    logic [XLEN-1:0]    r_pc;
    logic [63:0]        r_instret;
    logic               r_fetch_valid;
    logic               r_commit_ready;
    logic               r_exc_valid;
    logic [CAUSE_W-1:0] r_exc_cause;
    logic [XLEN-1:0]    r_exc_pc;
    logic [XLEN-1:0]    r_exc_tval;

    logic [XLEN-1:0]    w_next_pc;
    logic               w_is_exc;
    logic [CAUSE_W-1:0] w_exc_cause;
    logic [XLEN-1:0]    w_exc_tval;

    pc_redirect_mux #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_redirect (
        .i_pc          (r_pc),
        .i_br_taken    (i_br_taken),
        .i_br_target   (i_br_target),
        .i_is_jal      (i_is_jal),
        .i_jal_target  (i_jal_target),
        .i_is_jalr     (i_is_jalr),
        .i_jalr_target (i_jalr_target),
        .i_is_mret     (i_is_mret),
        .i_mepc        (i_mepc),
        .i_trap_req    (i_trap_req),
        .i_trap_cause  (i_trap_cause),
        .i_trap_tval   (i_trap_tval),
        .i_mtvec       (i_mtvec),
        .o_next_pc     (w_next_pc),
        .o_is_exc      (w_is_exc),
        .o_exc_cause   (w_exc_cause),
        .o_exc_tval    (w_exc_tval)
    );

    // Sequencing FSM with registered handshake outputs, PC, retire counter
    // and the one-cycle exception report
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= BOOT;
            r_pc           <= PC_RESET;
            r_instret      <= '0;
            r_fetch_valid  <= 1'b0;
            r_commit_ready <= 1'b0;
            r_exc_valid    <= 1'b0;
            r_exc_cause    <= '0;
            r_exc_pc       <= '0;
            r_exc_tval     <= '0;
        end else begin
            r_exc_valid <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state        <= FETCH;
                    r_fetch_valid  <= 1'b1;
                    r_commit_ready <= 1'b0;
                end
                FETCH: begin
                    if (i_fetch_ready) begin
                        r_state        <= EXEC;
                        r_fetch_valid  <= 1'b0;
                        r_commit_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    if (i_commit_valid) begin
                        r_state        <= FETCH;
                        r_fetch_valid  <= 1'b1;
                        r_commit_ready <= 1'b0;
                        r_pc           <= w_next_pc;
                        if (w_is_exc) begin
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= w_exc_cause;
                            r_exc_pc    <= r_pc;
                            r_exc_tval  <= w_exc_tval;
                        end else begin
                            r_instret <= r_instret + 64'd1;
                        end
                    end
                end
                default: begin
                    r_state        <= BOOT;
                    r_fetch_valid  <= 1'b0;
                    r_commit_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_fetch_valid  = r_fetch_valid;
    assign o_fetch_pc     = r_pc;
    assign o_pc           = r_pc;
    assign o_commit_ready = r_commit_ready;
    assign o_exc_valid    = r_exc_valid;
    assign o_exc_cause    = r_exc_cause;
    assign o_exc_pc       = r_exc_pc;
    assign o_exc_tval     = r_exc_tval;
    assign o_instret      = r_instret;
    assign o_state        = r_state;

endmodule
